mac_psum_accumulator: RTL and testbench

- Sits directly downstream of the MAC array stage. Consumes its registered reduction result (RES/VALID_OUT) as a stream of signed partial sums.
- Accumulates CFG_LEN consecutive partials per output point, e.g. kernel taps × channel groups. Applies signed saturation and pushes each finished output into a 2-entry output FIFO with a valid/ready interface.
- The MAC stage has no backpressure. This block absorbs bursts and flags any loss.

---
 rtl/mac_psum_accumulator.sv | 199 +++++++++++++++++++
 tb/tb_mac_psum_accumulator.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_psum_accumulator.sv
// Accumulates CFG_LEN signed partial sums per output point with saturation and
// queues finished results in a 2-entry valid/ready FIFO; drops are flagged as OVERRUN.
module mac_psum_accumulator #(
   parameter int unsigned IN_WIDTH  = 18,
   parameter int unsigned ACC_WIDTH = 32,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 NRST,
   input  logic                 START,
   input  logic [CNT_WIDTH-1:0] CFG_LEN,
   input  logic [CNT_WIDTH-1:0] CFG_NUM_OUT,
   input  logic                 VALID_IN,
   input  logic [IN_WIDTH-1:0]  IN_DATA,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [ACC_WIDTH-1:0] OUT_DATA,
   output logic                 OUT_SAT,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 OVERRUN
);

   localparam int unsigned SUM_WIDTH = ACC_WIDTH + 1;
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                 state_q, state_nxt;
   logic [ACC_WIDTH-1:0]   acc_q, acc_nxt;
   logic                   sat_q, sat_nxt;
   logic [CNT_WIDTH-1:0]   tap_q, tap_nxt;
   logic [CNT_WIDTH-1:0]   out_cnt_q, out_cnt_nxt;
   logic [CNT_WIDTH-1:0]   len_q, len_nxt;
   logic [CNT_WIDTH-1:0]   num_q, num_nxt;
   logic [ACC_WIDTH-1:0]   head_data_q, head_data_nxt;
   logic                   head_sat_q, head_sat_nxt;
   logic [ACC_WIDTH-1:0]   tail_data_q, tail_data_nxt;
   logic                   tail_sat_q, tail_sat_nxt;
   logic [1:0]             fifo_cnt_q, fifo_cnt_nxt;
   logic                   out_valid_q, out_valid_nxt;
   logic                   busy_q, busy_nxt;
   logic                   done_q, done_nxt;
   logic                   overrun_q, overrun_nxt;

   logic [SUM_WIDTH-1:0]   in_ext;
   logic [SUM_WIDTH-1:0]   sum;
   logic                   sat_now;
   logic [ACC_WIDTH-1:0]   clamped;
   logic                   push;
   logic                   pop;

   // Next-state, datapath and FIFO bookkeeping
   always_comb begin
      state_nxt     = state_q;
      acc_nxt       = acc_q;
      sat_nxt       = sat_q;
      tap_nxt       = tap_q;
      out_cnt_nxt   = out_cnt_q;
      len_nxt       = len_q;
      num_nxt       = num_q;
      head_data_nxt = head_data_q;
      head_sat_nxt  = head_sat_q;
      tail_data_nxt = tail_data_q;
      tail_sat_nxt  = tail_sat_q;
      fifo_cnt_nxt  = fifo_cnt_q;
      overrun_nxt   = overrun_q;
      done_nxt      = 1'b0;
      push          = 1'b0;

      in_ext  = {{(SUM_WIDTH-IN_WIDTH){IN_DATA[IN_WIDTH-1]}}, IN_DATA};
      sum     = {acc_q[ACC_WIDTH-1], acc_q} + in_ext;
      sat_now = sum[SUM_WIDTH-1] != sum[ACC_WIDTH-1];
      clamped = sat_now ? (sum[SUM_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
      pop     = out_valid_q && OUT_READY;

      case (state_q)
         IDLE: begin
            if (START) begin
               len_nxt     = (CFG_LEN == '0) ? CNT_WIDTH'(1) : CFG_LEN;
               num_nxt     = (CFG_NUM_OUT == '0) ? CNT_WIDTH'(1) : CFG_NUM_OUT;
               acc_nxt     = '0;
               sat_nxt     = 1'b0;
               tap_nxt     = '0;
               out_cnt_nxt = '0;
               overrun_nxt = 1'b0;
               state_nxt   = ACCUM;
            end
         end
         ACCUM: begin
            if (VALID_IN) begin
               if (tap_q == len_q - CNT_WIDTH'(1)) begin
                  push        = 1'b1;
                  acc_nxt     = '0;
                  sat_nxt     = 1'b0;
                  tap_nxt     = '0;
                  out_cnt_nxt = out_cnt_q + CNT_WIDTH'(1);
                  if (out_cnt_q == num_q - CNT_WIDTH'(1)) begin
                     done_nxt  = 1'b1;
                     state_nxt = IDLE;
                  end
               end else begin
                  acc_nxt = clamped;
                  sat_nxt = sat_q | sat_now;
                  tap_nxt = tap_q + CNT_WIDTH'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Shift FIFO: head register keeps its last value once drained
      case (fifo_cnt_q)
         2'd0: begin
            if (push) begin
               head_data_nxt = clamped;
               head_sat_nxt  = sat_q | sat_now;
               fifo_cnt_nxt  = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_data_nxt = clamped;
               head_sat_nxt  = sat_q | sat_now;
            end else if (push) begin
               tail_data_nxt = clamped;
               tail_sat_nxt  = sat_q | sat_now;
               fifo_cnt_nxt  = 2'd2;
            end else if (pop) begin
               fifo_cnt_nxt  = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               head_data_nxt = tail_data_q;
               head_sat_nxt  = tail_sat_q;
               if (push) begin
                  tail_data_nxt = clamped;
                  tail_sat_nxt  = sat_q | sat_now;
               end else begin
                  fifo_cnt_nxt  = 2'd1;
               end
            end else if (push) begin
               overrun_nxt = 1'b1;
            end
         end
      endcase

      out_valid_nxt = fifo_cnt_nxt != 2'd0;
      busy_nxt      = state_nxt == ACCUM;
   end

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         sat_q       <= 1'b0;
         tap_q       <= '0;
         out_cnt_q   <= '0;
         len_q       <= CNT_WIDTH'(1);
         num_q       <= CNT_WIDTH'(1);
         head_data_q <= '0;
         head_sat_q  <= 1'b0;
         tail_data_q <= '0;
         tail_sat_q  <= 1'b0;
         fifo_cnt_q  <= 2'd0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         acc_q       <= acc_nxt;
         sat_q       <= sat_nxt;
         tap_q       <= tap_nxt;
         out_cnt_q   <= out_cnt_nxt;
         len_q       <= len_nxt;
         num_q       <= num_nxt;
         head_data_q <= head_data_nxt;
         head_sat_q  <= head_sat_nxt;
         tail_data_q <= tail_data_nxt;
         tail_sat_q  <= tail_sat_nxt;
         fifo_cnt_q  <= fifo_cnt_nxt;
         out_valid_q <= out_valid_nxt;
         busy_q      <= busy_nxt;
         done_q      <= done_nxt;
         overrun_q   <= overrun_nxt;
      end
   end

   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = head_data_q;
   assign OUT_SAT   = head_sat_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_mac_psum_accumulator.sv
// Directed and randomized checks of mac_psum_accumulator against a queue-based
// model of accepted outputs; each consumer pop is compared to the model.
module tb_mac_psum_accumulator;

   localparam int unsigned IN_WIDTH  = 18;
   localparam int unsigned ACC_WIDTH = 20;
   localparam int unsigned CNT_WIDTH = 16;
   localparam longint      ACC_MAX   = 524287;
   localparam longint      ACC_MIN   = -524288;

   logic                 CLK;
   logic                 NRST;
   logic                 START;
   logic [CNT_WIDTH-1:0] CFG_LEN;
   logic [CNT_WIDTH-1:0] CFG_NUM_OUT;
   logic                 VALID_IN;
   logic [IN_WIDTH-1:0]  IN_DATA;
   logic                 OUT_VALID;
   logic                 OUT_READY;
   logic [ACC_WIDTH-1:0] OUT_DATA;
   logic                 OUT_SAT;
   logic                 BUSY;
   logic                 DONE;
   logic                 OVERRUN;

   mac_psum_accumulator #(
      .IN_WIDTH (IN_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .CLK        (CLK),
      .NRST       (NRST),
      .START      (START),
      .CFG_LEN    (CFG_LEN),
      .CFG_NUM_OUT(CFG_NUM_OUT),
      .VALID_IN   (VALID_IN),
      .IN_DATA    (IN_DATA),
      .OUT_VALID  (OUT_VALID),
      .OUT_READY  (OUT_READY),
      .OUT_DATA   (OUT_DATA),
      .OUT_SAT    (OUT_SAT),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .OVERRUN    (OVERRUN)
   );

   typedef struct {
      longint data;
      longint sat;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic beat(input longint v);
      VALID_IN = 1'b1;
      IN_DATA  = IN_WIDTH'(v);
      tick();
      VALID_IN = 1'b0;
   endtask

   task automatic start_job(input int len, input int num);
      START       = 1'b1;
      CFG_LEN     = CNT_WIDTH'(len);
      CFG_NUM_OUT = CNT_WIDTH'(num);
      tick();
      START       = 1'b0;
   endtask

   task automatic expect_out(input longint d, input longint s);
      exp_t e;
      e.data = d;
      e.sat  = s;
      exp_q.push_back(e);
   endtask

   // Consumer side: every handshake must match the oldest expected result
   always @(negedge CLK) begin
      if (NRST && OUT_VALID && OUT_READY) begin
         if (exp_q.size() == 0) begin
            chk("pop_unexpected", longint'(exp_q.size()), 1);
         end else begin
            chk("pop_data", longint'($signed(OUT_DATA)), exp_q[0].data);
            chk("pop_sat", longint'(OUT_SAT), exp_q[0].sat);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      longint acc;
      longint sat;
      longint v;
      int     len;
      int     num;

      NRST = 1'b0; START = 1'b0; CFG_LEN = '0; CFG_NUM_OUT = '0;
      VALID_IN = 1'b0; IN_DATA = '0; OUT_READY = 1'b1;
      tick(); tick();
      chk("rst_valid", longint'(OUT_VALID), 0);
      chk("rst_data", longint'(OUT_DATA), 0);
      chk("rst_sat", longint'(OUT_SAT), 0);
      chk("rst_busy", longint'(BUSY), 0);
      chk("rst_done", longint'(DONE), 0);
      chk("rst_overrun", longint'(OVERRUN), 0);
      NRST = 1'b1;
      tick();

      // Basic two-output job
      start_job(3, 2);
      chk("basic_busy", longint'(BUSY), 1);
      expect_out(13, 0);
      expect_out(250, 0);
      beat(5); beat(-2);
      chk("basic_not_yet", longint'(OUT_VALID), 0);
      beat(10);
      chk("basic_lat1_valid", longint'(OUT_VALID), 1);
      chk("basic_lat1_data", longint'($signed(OUT_DATA)), 13);
      beat(100);
      chk("basic_drained", longint'(OUT_VALID), 0);
      beat(200); beat(-50);
      chk("basic_lat2_data", longint'($signed(OUT_DATA)), 250);
      chk("basic_done", longint'(DONE), 1);
      chk("basic_busy_low", longint'(BUSY), 0);
      tick();
      chk("basic_done_pulse", longint'(DONE), 0);

      // Positive and negative saturation
      start_job(8, 1);
      expect_out(ACC_MAX, 1);
      repeat (8) beat(131071);
      chk("satp_data", longint'($signed(OUT_DATA)), ACC_MAX);
      chk("satp_flag", longint'(OUT_SAT), 1);
      chk("satp_done", longint'(DONE), 1);
      tick();
      start_job(8, 1);
      expect_out(ACC_MIN, 1);
      repeat (8) beat(-131072);
      chk("satn_data", longint'($signed(OUT_DATA)), ACC_MIN);
      chk("satn_flag", longint'(OUT_SAT), 1);
      tick();

      // Backpressure with overrun
      OUT_READY = 1'b0;
      start_job(1, 4);
      expect_out(1, 0);
      expect_out(2, 0);
      beat(1); beat(2);
      chk("bp_no_overrun_yet", longint'(OVERRUN), 0);
      beat(3);
      chk("bp_overrun", longint'(OVERRUN), 1);
      chk("bp_head", longint'($signed(OUT_DATA)), 1);
      beat(4);
      chk("bp_done", longint'(DONE), 1);
      tick(); tick();
      chk("bp_stall_valid", longint'(OUT_VALID), 1);
      chk("bp_stall_head", longint'($signed(OUT_DATA)), 1);
      OUT_READY = 1'b1;
      tick();
      chk("bp_second_head", longint'($signed(OUT_DATA)), 2);
      tick();
      chk("bp_empty", longint'(OUT_VALID), 0);
      chk("bp_hold_data", longint'($signed(OUT_DATA)), 2);
      chk("bp_overrun_sticky", longint'(OVERRUN), 1);

      // Push and pop together while full
      OUT_READY = 1'b0;
      start_job(1, 3);
      chk("pp_overrun_cleared", longint'(OVERRUN), 0);
      expect_out(7, 0); expect_out(8, 0); expect_out(9, 0);
      beat(7); beat(8);
      OUT_READY = 1'b1;
      beat(9);
      chk("pp_overrun", longint'(OVERRUN), 0);
      chk("pp_head", longint'($signed(OUT_DATA)), 8);
      chk("pp_valid", longint'(OUT_VALID), 1);
      tick(); tick();
      chk("pp_empty", longint'(OUT_VALID), 0);

      // VALID_IN in IDLE, START with len 0 and a simultaneous beat
      beat(55); beat(56);
      chk("idle_ignored", longint'(OUT_VALID), 0);
      VALID_IN = 1'b1; IN_DATA = IN_WIDTH'(77);
      start_job(0, 2);
      VALID_IN = 1'b0;
      chk("start_beat_ignored", longint'(OUT_VALID), 0);
      expect_out(3, 0); expect_out(-4, 0);
      beat(3);
      chk("len0_out1", longint'($signed(OUT_DATA)), 3);
      beat(-4);
      chk("len0_out2", longint'($signed(OUT_DATA)), -4);
      chk("len0_done", longint'(DONE), 1);
      tick();

      // START while accumulating must not disturb the job
      start_job(2, 2);
      expect_out(30, 0); expect_out(2, 0);
      beat(10);
      start_job(5, 9);
      chk("restart_busy", longint'(BUSY), 1);
      beat(20);
      chk("restart_out1", longint'($signed(OUT_DATA)), 30);
      beat(1); beat(1);
      chk("restart_done", longint'(DONE), 1);
      tick();

      // Reset in the middle of a job with a pending FIFO entry
      OUT_READY = 1'b0;
      start_job(3, 2);
      beat(1); beat(2); beat(3); beat(4); beat(5);
      chk("mid_pending", longint'(OUT_VALID), 1);
      NRST = 1'b0;
      tick();
      exp_q.delete();
      chk("mid_rst_valid", longint'(OUT_VALID), 0);
      chk("mid_rst_data", longint'(OUT_DATA), 0);
      chk("mid_rst_busy", longint'(BUSY), 0);
      chk("mid_rst_done", longint'(DONE), 0);
      NRST = 1'b1; OUT_READY = 1'b1;
      tick();
      start_job(3, 1);
      expect_out(60, 0);
      beat(10); beat(20); beat(30);
      chk("mid_new_sum", longint'($signed(OUT_DATA)), 60);
      tick();

      // Randomized jobs checked against saturating arithmetic
      for (int j = 0; j < 12; j++) begin
         len = int'($urandom_range(1, 6));
         num = int'($urandom_range(1, 4));
         start_job(len, num);
         for (int o = 0; o < num; o++) begin
            acc = 0;
            sat = 0;
            for (int k = 0; k < len; k++) begin
               v = longint'($urandom_range(0, 262143)) - 131072;
               acc = acc + v;
               if (acc > ACC_MAX) begin acc = ACC_MAX; sat = 1; end
               if (acc < ACC_MIN) begin acc = ACC_MIN; sat = 1; end
               if (k == len - 1) expect_out(acc, sat);
               repeat ($urandom_range(0, 2)) tick();
               beat(v);
            end
         end
         chk("rnd_done", longint'(DONE), 1);
         tick();
      end

      tick(); tick(); tick();
      chk("final_queue_empty", longint'(exp_q.size()), 0);
      chk("final_overrun", longint'(OVERRUN), 0);
      chk("final_busy", longint'(BUSY), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
